// File: rtl/openhw_ahbsram_sub.sv
// openhw_ahbsram_sub: AHB-Lite subordinate fronting a single-port SRAM.
// Adds wait states on NONSEQ only, two-cycle ERROR, and byte-merged write-to-read forwarding.
// Ports: HCLK/HRESET (async, active high), AHB address phase (HSEL, HADDR, HTRANS,
//   HWRITE, HSIZE, HBURST), HWDATA in data phase, HREADY in; HREADYOUT, HRESP,
//   HRDATA out.
module openhw_ahbsram_sub #(
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH       = 1024,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = ADDR_WIDTH - LB;
  localparam int XW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2
  } state_e;

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic                  wr_q;
  logic                  burst_q;
  logic                  rdy_q;
  logic                  resp_q;
  logic [XW-1:0]         widx_q;
  logic [NB-1:0]         strb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  in_range;
  logic                  size_ok;
  logic                  aligned;
  logic                  legal;
  logic                  wfin;
  logic [LB-1:0]         off;
  logic [XW-1:0]         idx;
  logic [NB-1:0]         strb;
  logic [DATA_WIDTH-1:0] fwd;
  logic                  unused_hburst;

  assign unused_hburst = ^HBURST;

  assign accept   = HSEL & HREADY & HTRANS[1];
  assign off      = HADDR[LB-1:0];
  assign idx      = HADDR[LB +: XW];
  assign in_range = HADDR[ADDR_WIDTH-1:LB] < IW'(DEPTH);
  assign size_ok  = HSIZE <= 3'(LB);
  assign aligned  = (off & LB'((1 << HSIZE) - 1)) == '0;
  // SEQ is only legal while a burst is open (BUSY keeps it open)
  assign legal    = in_range & size_ok & aligned & (~HTRANS[0] | burst_q);
  assign wfin     = (state_q == S_DATA) & wr_q & HREADY;

  always_comb begin
    strb = '0;
    for (int i = 0; i < NB; i++)
      strb[i] = (i >= int'(off)) && (i < int'(off) + (1 << HSIZE));
  end

  // A read taken on the edge that commits a write sees that write's lanes
  always_comb begin
    fwd = mem[idx];
    for (int i = 0; i < NB; i++)
      if (wfin && (widx_q == idx) && strb_q[i])
        fwd[8*i +: 8] = HWDATA[8*i +: 8];
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET && wfin)
      for (int i = 0; i < NB; i++)
        if (strb_q[i])
          mem[widx_q][8*i +: 8] <= HWDATA[8*i +: 8];
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      burst_q <= 1'b0;
      rdy_q   <= 1'b1;
      resp_q  <= 1'b0;
      widx_q  <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= S_DATA;
            rdy_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_ERR1: begin
          state_q <= S_ERR2;
          rdy_q   <= 1'b1;
          resp_q  <= 1'b1;
        end
        default: begin
          if (HREADY) begin
            rdy_q   <= 1'b1;
            resp_q  <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            if (accept && !legal) begin
              state_q <= S_ERR1;
              rdy_q   <= 1'b0;
              resp_q  <= 1'b1;
              burst_q <= 1'b0;
            end else if (accept) begin
              burst_q <= 1'b1;
              wr_q    <= HWRITE;
              widx_q  <= idx;
              strb_q  <= strb;
              if (!HWRITE)
                rdata_q <= fwd;
              if (!HTRANS[0] && (WAIT_STATES > 0)) begin
                state_q <= S_WAIT;
                rdy_q   <= 1'b0;
                cnt_q   <= CNT_INIT;
              end else begin
                state_q <= S_DATA;
              end
            end else begin
              state_q <= S_IDLE;
              if (!(HSEL && (HTRANS == 2'b01)))
                burst_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign HREADYOUT = rdy_q;
  assign HRESP     = resp_q;
  assign HRDATA    = rdata_q;

endmodule
